// File: rtl/vga_pkg.sv
// Shared VGA/VRAM definitions: default widths, arbiter state encodings and
// the two-way round-robin pick used by the VRAM write arbiter.
package vga_pkg;

  localparam int ADDR_W_DEF       = 15;
  localparam int DATA_W_DEF       = 3;
  localparam int GUARD_CYCLES_DEF = 4;
  localparam int MAX_WAIT_DEF     = 2047;

  typedef enum logic [1:0] {
    ST_DISP  = 2'd0,
    ST_GUARD = 2'd1,
    ST_ARB   = 2'd2
  } state_t;

  // ptr=0 favours port 0 on a tie, ptr=1 favours port 1.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] gnt;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a single pointer bit that moves to the
// other port after every grant.
module rr_arb2
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = i_en ? rr_pick(i_req, r_ptr) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_ptr <= 1'b0;
    end else if (o_gnt[0]) begin
      r_ptr <= 1'b1;
    end else if (o_gnt[1]) begin
      r_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM sharing: scan-out reads own the RAM during active video,
// two writers are round-robin arbitrated during blanking after a read drain.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter int MAX_WAIT     = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              vidon,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_gnt,
  output logic [1:0]        starve,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int GW = $clog2(GUARD_CYCLES + 2);
  localparam int WW = $clog2(MAX_WAIT + 1);

  state_t            r_state, w_state_next;
  logic [GW-1:0]     r_guard, w_guard_next;
  logic              w_arb_en;
  logic [1:0]        w_gnt;
  logic [1:0]        r_vid_d;
  logic              r_disp_valid;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;

  always_comb begin
    w_state_next = r_state;
    w_guard_next = r_guard;
    w_arb_en     = 1'b0;
    case (r_state)
      ST_DISP: begin
        if (!vidon) begin
          w_state_next = ST_GUARD;
          w_guard_next = GW'(GUARD_CYCLES);
        end
      end
      ST_GUARD: begin
        if (vidon) begin
          w_state_next = ST_DISP;
        end else begin
          w_guard_next = (r_guard == '0) ? '0 : r_guard - GW'(1);
          if (r_guard <= GW'(1)) w_state_next = ST_ARB;
        end
      end
      ST_ARB: begin
        // A rising vidon takes the RAM immediately, even over a pending write.
        if (vidon) w_state_next = ST_DISP;
        else       w_arb_en     = !clr;
      end
      default: w_state_next = ST_GUARD;
    endcase
  end

  rr_arb2 u_rr (
    .clk   (clk),
    .clr   (clr),
    .i_en  (w_arb_en),
    .i_req (wr_req),
    .o_gnt (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state      <= ST_GUARD;
      r_guard      <= GW'(GUARD_CYCLES);
      r_vid_d      <= '0;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_guard      <= w_guard_next;
      // Two stages here plus the output register match the addr->RAM->data path.
      r_vid_d      <= {r_vid_d[0], vidon};
      r_disp_valid <= r_vid_d[1];
      r_disp_data  <= r_vid_d[1] ? ram_rdata : '0;
      r_ram_we     <= |w_gnt;
      if (vidon) begin
        r_ram_addr <= disp_addr;
      end else if (w_gnt[0]) begin
        r_ram_addr  <= wr_addr0;
        r_ram_wdata <= wr_data0;
      end else if (w_gnt[1]) begin
        r_ram_addr  <= wr_addr1;
        r_ram_wdata <= wr_data1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [WW-1:0] r_wait;
      logic          r_starve;

      always_ff @(posedge clk) begin
        if (clr) begin
          r_wait   <= '0;
          r_starve <= 1'b0;
        end else if (!wr_req[gi] || w_gnt[gi]) begin
          r_wait <= '0;
        end else if (r_wait != WW'(MAX_WAIT)) begin
          r_wait <= r_wait + WW'(1);
          if (r_wait == WW'(MAX_WAIT - 1)) r_starve <= 1'b1;
        end
      end

      assign starve[gi] = r_starve;
    end
  endgenerate

  assign wr_gnt     = w_gnt;
  assign disp_valid = r_disp_valid;
  assign disp_data  = r_disp_data;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;

endmodule
